instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 182 ++++++++++++++++++
 tb/tb_instruction_fetch.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Single-outstanding-request instruction fetch unit. It issues a read for
//   the word at pc, captures the returned word into the instruction register,
//   and holds it until the decode stage consumes it. After consumption pc
//   advances by 4 and the next fetch begins. A redirect (branch/jump) from any
//   state reloads pc with the word-aligned target and restarts fetching.
//
// Optional feature (macro FETCH_TIMEOUT_EN):
//   When defined, a counter tracks consecutive request cycles without mem_ack.
//   After TIMEOUT_CYCLES such cycles the unit parks in FAULT with mem_req low
//   and fetch_fault high, until reset or redirect. When undefined the request
//   waits forever and fetch_fault is tied low.
//
// Handshake semantics:
//   mem_req/mem_ack: mem_req is held high with a stable mem_addr until a cycle
//   in which mem_ack is sampled high; mem_rdata is taken in that same cycle.
//   mem_ack is ignored whenever mem_req is low.
//   instr_valid/decode_ready: a word is transferred to decode in a cycle where
//   instr_valid and decode_ready are both high; decode_ready is ignored while
//   instr_valid is low. redirect_valid overrides both handshakes that cycle.
//
// Ports:
//   clock          in   1   rising-edge clock
//   reset_n        in   1   asynchronous active-low reset
//   mem_req        out  1   instruction memory read request
//   mem_addr       out  32  fetch address (equals pc)
//   mem_ack        in   1   read complete, mem_rdata valid this cycle
//   mem_rdata      in   32  instruction word from memory
//   instruction    out  32  instruction register to decode
//   pc             out  32  address of held / in-flight instruction
//   pc_plus4       out  32  pc + 4 (wraps modulo 2^32)
//   instr_valid    out  1   instruction holds an unconsumed word
//   decode_ready   in   1   decode consumes instruction this cycle
//   redirect_valid in   1   branch/jump redirect request
//   redirect_pc    in   32  redirect target (low two bits dropped)
//   fetch_fault    out  1   sticky memory-timeout indication
//   dbg_state      out  2   current FSM state (debug observation only)
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        decode_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("instruction_fetch: TIMEOUT_CYCLES must be at least 1");
  end

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        tmo_hit;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counts consecutive unacknowledged request cycles. Any cycle that is not
  // a plain waiting request (ack, redirect, or another state) clears it, so
  // every entry into REQ starts from zero.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_REQ && !mem_ack && !redirect_valid) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Fires on the last tolerated waiting cycle, so the FSM leaves REQ after
  // exactly TIMEOUT_CYCLES request cycles.
  assign tmo_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_fault = (state_q == S_FAULT);
`else
  assign tmo_hit     = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // Next-state and datapath updates. Redirect is evaluated first so that it
  // wins over a coincident mem_ack (data dropped) or decode_ready (no +4).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;

    if (redirect_valid) begin
      state_d = S_REQ;
      pc_d    = {redirect_pc[31:2], 2'b00};
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_REQ;
        end
        S_REQ: begin
          if (mem_ack) begin
            instr_d = mem_rdata;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end else if (tmo_hit) begin
            state_d = S_FAULT;
          end
        end
        S_HOLD: begin
          if (decode_ready) begin
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b0;
            state_d = S_REQ;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= ResetPcAligned;
      instr_q <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Request is a pure function of state, so it stays high through a redirect
  // cycle and the new address simply appears on the next cycle.
  assign mem_req     = (state_q == S_REQ);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed vector table for the reset / fetch / hold / redirect / wrap
// scenarios, hand-written sequences for asynchronous reset mid-request and the
// timeout behaviour, then a randomized run compared every cycle against a
// transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TMO      = 16;
`ifdef FETCH_TIMEOUT_EN
  localparam bit          TMO_EN   = 1'b1;
`else
  localparam bit          TMO_EN   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clock;
  logic        reset_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        decode_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
  logic [1:0]  dbg_state;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  instruction_fetch #(
    .RESET_PC       (RESET_PC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .instruction    (instruction),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .instr_valid    (instr_valid),
    .decode_ready   (decode_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault),
    .dbg_state      (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_quiet();
    mem_ack        = 1'b0;
    mem_rdata      = 32'h0;
    decode_ready   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  // Leaves reset released at a falling edge; the DUT is in its first
  // post-reset cycle when this returns.
  task automatic apply_reset();
    @(negedge clock);
    reset_n = 1'b0;
    drive_quiet();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks what the fetch unit is doing as a transaction
  // (waiting for the first cycle, fetching, holding a word, faulted) and the
  // architectural values pc / instruction.
  // ---------------------------------------------------------------------------
  bit          m_idle, m_fetch, m_valid, m_fault;
  logic [31:0] m_pc, m_instr;
  int          m_wait;

  task automatic model_reset();
    m_idle  = 1'b1;
    m_fetch = 1'b0;
    m_valid = 1'b0;
    m_fault = 1'b0;
    m_pc    = RESET_PC & 32'hFFFF_FFFC;
    m_instr = 32'h0;
    m_wait  = 0;
  endtask

  // Called right after a rising edge with the inputs that were sampled there.
  task automatic model_step();
    if (redirect_valid) begin
      m_pc    = redirect_pc & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_fault = 1'b0;
      m_fetch = 1'b1;
      m_idle  = 1'b0;
      m_wait  = 0;
    end else if (m_idle) begin
      m_idle  = 1'b0;
      m_fetch = 1'b1;
      m_wait  = 0;
    end else if (m_fetch) begin
      if (mem_ack) begin
        m_instr = mem_rdata;
        m_valid = 1'b1;
        m_fetch = 1'b0;
      end else begin
        m_wait++;
        if (TMO_EN && m_wait >= TMO) begin
          m_fetch = 1'b0;
          m_fault = 1'b1;
        end
      end
    end else if (m_valid && decode_ready) begin
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b0;
      m_fetch = 1'b1;
      m_wait  = 0;
    end
  endtask

  task automatic check_model();
    check32("rnd_mem_req",     mem_req,     m_fetch);
    check32("rnd_mem_addr",    mem_addr,    m_pc);
    check32("rnd_pc",          pc,          m_pc);
    check32("rnd_pc_plus4",    pc_plus4,    m_pc + 32'd4);
    check32("rnd_instr_valid", instr_valid, m_valid);
    check32("rnd_instruction", instruction, m_instr);
    check32("rnd_fetch_fault", fetch_fault, m_fault);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: inputs applied during a cycle and the outputs
  // expected during that same cycle (all outputs are registered).
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  function automatic vec_t mk(logic ack, logic [31:0] rdata, logic rdy, logic redir,
                              logic [31:0] rpc, logic e_req, logic [31:0] e_pc,
                              logic e_valid, logic [31:0] e_instr);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_pc = e_pc; v.e_valid = e_valid; v.e_instr = e_instr;
    return v;
  endfunction

  initial begin
    int n_req;
    reset_n = 1'b0;
    drive_quiet();

    //               ack rdata          rdy redir rpc            req pc             vld instr
    vecs[0]  = mk(1, 32'hAAAA_AAAA, 0, 0, 32'h0,          0, 32'h0000_0000, 0, 32'h0);          // IDLE, ack ignored
    vecs[1]  = mk(0, 32'h0,         1, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0);          // REQ 1, ready ignored
    vecs[2]  = mk(0, 32'h0,         0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0);          // REQ 2
    vecs[3]  = mk(1, 32'h8C22_0004, 0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0);          // REQ 3, ack
    vecs[4]  = mk(1, 32'hDEAD_BEEF, 0, 0, 32'h0,          0, 32'h0000_0000, 1, 32'h8C22_0004);  // HOLD, ack ignored
    vecs[5]  = mk(0, 32'h0,         0, 0, 32'h0,          0, 32'h0000_0000, 1, 32'h8C22_0004);
    vecs[6]  = mk(0, 32'h0,         0, 0, 32'h0,          0, 32'h0000_0000, 1, 32'h8C22_0004);
    vecs[7]  = mk(0, 32'h0,         0, 0, 32'h0,          0, 32'h0000_0000, 1, 32'h8C22_0004);
    vecs[8]  = mk(0, 32'h0,         0, 0, 32'h0,          0, 32'h0000_0000, 1, 32'h8C22_0004);
    vecs[9]  = mk(0, 32'h0,         1, 0, 32'h0,          0, 32'h0000_0000, 1, 32'h8C22_0004);  // consume
    vecs[10] = mk(1, 32'h1111_1111, 0, 1, 32'h0000_0103,  1, 32'h0000_0004, 0, 32'h8C22_0004);  // redirect beats ack
    vecs[11] = mk(1, 32'h2222_2222, 0, 0, 32'h0,          1, 32'h0000_0100, 0, 32'h8C22_0004);
    vecs[12] = mk(0, 32'h0,         1, 1, 32'hFFFF_FFFE,  0, 32'h0000_0100, 1, 32'h2222_2222);  // redirect beats ready
    vecs[13] = mk(1, 32'h3333_3333, 0, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h2222_2222);
    vecs[14] = mk(0, 32'h0,         1, 0, 32'h0,          0, 32'hFFFF_FFFC, 1, 32'h3333_3333);  // consume at top
    vecs[15] = mk(0, 32'h0,         0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h3333_3333);  // wrapped

    // Reset state while reset_n is held low.
    #2;
    check32("rst_mem_req",     mem_req,     1'b0);
    check32("rst_pc",          pc,          RESET_PC);
    check32("rst_instruction", instruction, 32'h0);
    check32("rst_instr_valid", instr_valid, 1'b0);
    check32("rst_fetch_fault", fetch_fault, 1'b0);

    // --- Table-driven directed vectors -------------------------------------
    apply_reset();
    for (int i = 0; i < NV; i++) begin
      mem_ack        = vecs[i].ack;
      mem_rdata      = vecs[i].rdata;
      decode_ready   = vecs[i].rdy;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      #1;
      check32($sformatf("vec%0d_mem_req", i),     mem_req,     vecs[i].e_req);
      check32($sformatf("vec%0d_mem_addr", i),    mem_addr,    vecs[i].e_pc);
      check32($sformatf("vec%0d_pc", i),          pc,          vecs[i].e_pc);
      check32($sformatf("vec%0d_pc_plus4", i),    pc_plus4,    vecs[i].e_pc + 32'd4);
      check32($sformatf("vec%0d_instr_valid", i), instr_valid, vecs[i].e_valid);
      check32($sformatf("vec%0d_instruction", i), instruction, vecs[i].e_instr);
      check32($sformatf("vec%0d_fetch_fault", i), fetch_fault, 1'b0);
      @(posedge clock);
      @(negedge clock);
    end

    // --- Asynchronous reset between edges during a request ------------------
    drive_quiet();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    @(posedge clock);
    #1;
    drive_quiet();
    @(negedge clock);
    check32("pre_rst_req",  mem_req,  1'b1);
    check32("pre_rst_addr", mem_addr, 32'h0000_0040);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check32("async_rst_mem_req",     mem_req,     1'b0);
    check32("async_rst_pc",          pc,          RESET_PC);
    check32("async_rst_mem_addr",    mem_addr,    RESET_PC);
    check32("async_rst_instruction", instruction, 32'h0);
    check32("async_rst_instr_valid", instr_valid, 1'b0);
    #1;
    reset_n   = 1'b1;
    mem_ack   = 1'b1;          // late ack for the abandoned request
    mem_rdata = 32'h5555_5555;
    @(posedge clock);
    #1;
    drive_quiet();
    @(negedge clock);
    check32("late_ack_req",   mem_req,     1'b1);
    check32("late_ack_valid", instr_valid, 1'b0);
    check32("late_ack_instr", instruction, 32'h0);
    @(negedge clock);
    check32("late_ack_valid2", instr_valid, 1'b0);

    // --- Timeout behaviour ---------------------------------------------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    @(posedge clock);
    #1;
    drive_quiet();
    n_req = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (mem_req) n_req++;
      else break;
    end
    check32("tmo_req_cycles", n_req, TMO_EN ? TMO : 40);
    check32("tmo_fault",      fetch_fault, TMO_EN);
    check32("tmo_mem_req",    mem_req,     !TMO_EN);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0301;
    @(posedge clock);
    #1;
    drive_quiet();
    @(negedge clock);
    check32("tmo_clr_fault", fetch_fault, 1'b0);
    check32("tmo_clr_req",   mem_req,     1'b1);
    check32("tmo_clr_addr",  mem_addr,    32'h0000_0300);

    // --- Randomized run against the reference model --------------------------
    apply_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      mem_ack        = ($urandom_range(0, 99) < 35);
      mem_rdata      = $urandom;
      decode_ready   = ($urandom_range(0, 99) < 50);
      redirect_valid = ($urandom_range(0, 99) < 6);
      redirect_pc    = $urandom;
      #1;
      check_model();
      @(posedge clock);
      model_step();
      @(negedge clock);
    end

    drive_quiet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
